gate_exhaustive_tester: RTL



---
 rtl/gate_exhaustive_tester.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/gate_exhaustive_tester.sv
// -----------------------------------------------------------------------------
// gate_exhaustive_tester
//
// Drives all four input combinations of a two-input gate under test, holds each
// one for SETTLE_CYCLES clocks, then samples the gate output and compares it
// with the selected Boolean function. Reports a per-combination fail vector,
// a mismatch count and pass/done.
//
// Optional build macro: GATE_TESTER_STOP_ON_FAIL_EN
//   When defined, the first mismatch ends the run at once and a_o/b_o stay on
//   the failing combination until the next accepted start or reset.
//
// Parameters:
//   SETTLE_CYCLES  cycles each combination is held before sampling (>= 1)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, sampled only in IDLE
//   func       in   3  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR,
//                      5 XNOR, 6/7 reserved
//   y_i        in   output of the gate under test
//   a_o, b_o   out  gate inputs, {a_o,b_o} = current combination index
//   busy       out  high whenever not IDLE
//   done       out  one-cycle pulse at the end of a run
//   pass       out  last run had no mismatches
//   fail_vec   out  4  bit k set if combination k mismatched
//   err_count  out  3  number of mismatches, 0..4
// -----------------------------------------------------------------------------
module gate_exhaustive_tester #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] func,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]       func_q, func_d;
    logic [3:0]       fail_vec_q, fail_vec_d;
    logic [2:0]       err_count_q, err_count_d;
    logic             pass_q, pass_d;

    logic             mismatch;
    logic [3:0]       fail_vec_upd;
    logic [2:0]       err_count_upd;

    function automatic logic expected_y(input logic [2:0] f, input logic a, input logic b);
        case (f)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            wait_cnt_q  <= '0;
            func_q      <= 3'd0;
            fail_vec_q  <= 4'd0;
            err_count_q <= 3'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
            func_q      <= func_d;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

    // Result of the sample taken in this cycle (only used in SAMPLE)
    assign mismatch      = (y_i != expected_y(func_q, idx_q[1], idx_q[0]));
    assign fail_vec_upd  = fail_vec_q | (mismatch ? (4'b0001 << idx_q) : 4'b0000);
    assign err_count_upd = err_count_q + {2'b00, mismatch};

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        func_d      = func_q;
        fail_vec_d  = fail_vec_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d = 2'd0;
                    if (func <= 3'd5) begin
                        func_d      = func;
                        wait_cnt_d  = '0;
                        fail_vec_d  = 4'd0;
                        err_count_d = 3'd0;
                        pass_d      = 1'b0;
                        state_d     = ST_WAIT;
                    end else begin
                        // Reserved function: every combination counts as failed.
                        fail_vec_d  = 4'hF;
                        err_count_d = 3'd4;
                        pass_d      = 1'b0;
                        state_d     = ST_FINISH;
                    end
                end
            end

            ST_WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    wait_cnt_d = '0;
                    state_d    = ST_SAMPLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_SAMPLE: begin
                fail_vec_d  = fail_vec_upd;
                err_count_d = err_count_upd;
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
                if (idx_q == 2'd3 || mismatch) begin
`else
                if (idx_q == 2'd3) begin
`endif
                    // pass must already reflect the final sample in FINISH
                    pass_d  = (fail_vec_upd == 4'd0);
                    state_d = ST_FINISH;
                end else begin
                    idx_d      = idx_q + 2'd1;
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
                // Keep pointing at the failing combination for inspection.
                idx_d = (fail_vec_q != 4'd0) ? idx_q : 2'd0;
`else
                idx_d = 2'd0;
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        a_o       = idx_q[1];
        b_o       = idx_q[0];
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FINISH);
        pass      = pass_q;
        fail_vec  = fail_vec_q;
        err_count = err_count_q;
    end

endmodule
